// File: rtl/flash_byte_reader.sv
// Streams bytes out of 32-bit flash words one lane at a time, walking forward or backward
// through an inclusive word window and wrapping at either end.
module flash_byte_reader (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_reverse,
  input  logic [22:0] i_start_word,
  input  logic [1:0]  i_start_byte,
  input  logic [22:0] i_lo_word,
  input  logic [22:0] i_hi_word,
  output logic [22:0] o_flash_address,
  output logic        o_flash_read,
  input  logic        i_flash_waitrequest,
  input  logic [31:0] i_flash_readdata,
  input  logic        i_flash_readdatavalid,
  output logic [7:0]  o_out_byte,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic        o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HAVE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [22:0] r_cur_word;
  logic [22:0] w_cur_word_nxt;
  logic [1:0]  r_cur_byte;
  logic [1:0]  w_cur_byte_nxt;
  logic [31:0] r_word_buf;
  logic [31:0] w_word_buf_nxt;
  logic        r_stop_pend;
  logic        w_stop_pend_nxt;
  logic [22:0] w_adv_word;
  logic [1:0]  w_adv_byte;

  // Window wrap is checked before the +/-1 step so it overrides the modulo-2^23 rollover.
  always_comb begin
    w_adv_word = r_cur_word;
    w_adv_byte = r_cur_byte;
    if (!i_reverse) begin
      w_adv_byte = r_cur_byte + 2'd1;
      if (r_cur_byte == 2'd3)
        w_adv_word = (r_cur_word == i_hi_word) ? i_lo_word : r_cur_word + 23'd1;
    end else begin
      w_adv_byte = r_cur_byte - 2'd1;
      if (r_cur_byte == 2'd0)
        w_adv_word = (r_cur_word == i_lo_word) ? i_hi_word : r_cur_word - 23'd1;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_word_nxt  = r_cur_word;
    w_cur_byte_nxt  = r_cur_byte;
    w_word_buf_nxt  = r_word_buf;
    w_stop_pend_nxt = r_stop_pend;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          w_cur_word_nxt = i_start_word;
          w_cur_byte_nxt = i_start_byte;
          w_state_nxt    = S_REQ;
        end
      end
      S_REQ: begin
        if (i_stop)
          w_stop_pend_nxt = 1'b1;
        if (!i_flash_waitrequest)
          w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_stop)
          w_stop_pend_nxt = 1'b1;
        // A stop that lands while the read is in flight lets the word arrive and throws it away.
        if (i_flash_readdatavalid) begin
          if (r_stop_pend || i_stop) begin
            w_stop_pend_nxt = 1'b0;
            w_state_nxt     = S_IDLE;
          end else begin
            w_word_buf_nxt = i_flash_readdata;
            w_state_nxt    = S_HAVE;
          end
        end
      end
      S_HAVE: begin
        if (i_out_ready) begin
          w_cur_word_nxt = w_adv_word;
          w_cur_byte_nxt = w_adv_byte;
          if (i_stop)
            w_state_nxt = S_IDLE;
          else if (w_adv_word != r_cur_word)
            w_state_nxt = S_REQ;
        end else if (i_stop) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cur_word  <= '0;
      r_cur_byte  <= '0;
      r_word_buf  <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_word  <= w_cur_word_nxt;
      r_cur_byte  <= w_cur_byte_nxt;
      r_word_buf  <= w_word_buf_nxt;
      r_stop_pend <= w_stop_pend_nxt;
    end
  end

  always_comb begin
    case (r_cur_byte)
      2'd0:    o_out_byte = r_word_buf[7:0];
      2'd1:    o_out_byte = r_word_buf[15:8];
      2'd2:    o_out_byte = r_word_buf[23:16];
      default: o_out_byte = r_word_buf[31:24];
    endcase
  end

  // Outputs decode straight from the state register so reset clears them without a clock.
  assign o_flash_address = r_cur_word;
  assign o_flash_read    = (r_state == S_REQ);
  assign o_out_valid     = (r_state == S_HAVE);
  assign o_busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_flash_byte_reader.sv
// Directed bench for flash_byte_reader: a small flash responder plus a linear
// sequence of start/stream/stop scenarios with hand-computed expectations.
module tb_flash_byte_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        reverse = 1'b0;
  logic [22:0] startWord = '0;
  logic [1:0]  startByte = '0;
  logic [22:0] loWord = 23'h10;
  logic [22:0] hiWord = 23'h11;
  logic [22:0] flashAddress;
  logic        flashRead;
  logic        flashWaitrequest = 1'b0;
  logic [31:0] flashReaddata = '0;
  logic        flashRdv = 1'b0;
  logic [7:0]  outByte;
  logic        outValid;
  logic        outReady = 1'b0;
  logic        busy;

  int checkCount = 0;
  int failCount = 0;

  int          stallLeft = 0;
  int          latency = 0;
  int          readCount = 0;
  int          readsBefore = 0;
  logic        forceRdv = 1'b0;
  logic        pendActive = 1'b0;
  int          pendCount = 0;
  logic [22:0] pendAddr = '0;
  logic [22:0] addrLog[$];
  logic [7:0]  gotBytes[$];
  logic        sawAny;

  logic [7:0]  expFwd [7] = '{8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
  logic [7:0]  expRev [7] = '{8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44};
  logic [22:0] expFwdAddr [3] = '{23'h10, 23'h11, 23'h10};
  logic [22:0] expRevAddr [3] = '{23'h11, 23'h10, 23'h11};

  always #5 clk = ~clk;

  flash_byte_reader dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_start               (start),
    .i_stop                (stop),
    .i_reverse             (reverse),
    .i_start_word          (startWord),
    .i_start_byte          (startByte),
    .i_lo_word             (loWord),
    .i_hi_word             (hiWord),
    .o_flash_address       (flashAddress),
    .o_flash_read          (flashRead),
    .i_flash_waitrequest   (flashWaitrequest),
    .i_flash_readdata      (flashReaddata),
    .i_flash_readdatavalid (flashRdv),
    .o_out_byte            (outByte),
    .o_out_valid           (outValid),
    .i_out_ready           (outReady),
    .o_busy                (busy)
  );

  function automatic logic [31:0] memRead(input logic [22:0] addr);
    case (addr)
      23'h10:  return 32'hDDCC_BBAA;
      23'h11:  return 32'h4433_2211;
      default: return {9'd0, addr};
    endcase
  endfunction

  // Flash model: inputs change on the falling edge so the DUT sees them settled at the rising edge.
  always @(negedge clk) begin
    flashRdv = 1'b0;
    if (forceRdv) begin
      flashRdv = 1'b1;
      flashReaddata = 32'hFFFF_FFFF;
    end else if (pendActive) begin
      if (pendCount == 0) begin
        flashRdv = 1'b1;
        flashReaddata = memRead(pendAddr);
        pendActive = 1'b0;
      end else begin
        pendCount--;
      end
    end
    if (flashRead && !rst) begin
      if (stallLeft > 0) begin
        flashWaitrequest = 1'b1;
        stallLeft--;
      end else begin
        flashWaitrequest = 1'b0;
        pendActive = 1'b1;
        pendCount = latency;
        pendAddr = flashAddress;
        readCount++;
        addrLog.push_back(flashAddress);
      end
    end else begin
      flashWaitrequest = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [22:0] w, input logic [1:0] b, input logic rev, input logic ready);
    @(negedge clk);
    startWord = w;
    startByte = b;
    reverse = rev;
    outReady = ready;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collectStream(input int n);
    int cyc = 0;
    gotBytes.delete();
    while (gotBytes.size() < n && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (outValid && outReady)
        gotBytes.push_back(outByte);
    end
  endtask

  task automatic waitValid(input string tag);
    int cyc = 0;
    while (!outValid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput(tag, 32'(outValid), 32'd1);
  endtask

  task automatic stopPulse();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_read", 32'(flashRead), 32'd0);
    checkOutput("rst_valid", 32'(outValid), 32'd0);
    checkOutput("rst_addr", 32'(flashAddress), 32'd0);
    checkOutput("rst_byte", 32'(outByte), 32'd0);
    rst = 1'b0;

    $display("[TB] start and stop together");
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    checkOutput("startstop_busy", 32'(busy), 32'd0);
    checkOutput("startstop_read", 32'(flashRead), 32'd0);

    $display("[TB] forward stream with wrap");
    addrLog.delete();
    applyStimulus(23'h10, 2'd2, 1'b0, 1'b1);
    checkOutput("fwd_latency_read", 32'(flashRead), 32'd1);
    collectStream(7);
    stopPulse();
    checkOutput("fwd_stop_busy", 32'(busy), 32'd0);
    checkOutput("fwd_nbytes", 32'(gotBytes.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      checkOutput($sformatf("fwd_byte%0d", i), 32'(gotBytes[i]), 32'(expFwd[i]));
    checkOutput("fwd_nreads", 32'(addrLog.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("fwd_addr%0d", i), 32'(addrLog[i]), 32'(expFwdAddr[i]));

    $display("[TB] reverse stream with wrap");
    addrLog.delete();
    applyStimulus(23'h11, 2'd1, 1'b1, 1'b1);
    collectStream(7);
    stopPulse();
    checkOutput("rev_stop_busy", 32'(busy), 32'd0);
    checkOutput("rev_nbytes", 32'(gotBytes.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      checkOutput($sformatf("rev_byte%0d", i), 32'(gotBytes[i]), 32'(expRev[i]));
    checkOutput("rev_nreads", 32'(addrLog.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("rev_addr%0d", i), 32'(addrLog[i]), 32'(expRevAddr[i]));

    $display("[TB] flash stall and consumer backpressure");
    stallLeft = 5;
    latency = 0;
    readsBefore = readCount;
    applyStimulus(23'h10, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("stall_read%0d", i), 32'(flashRead), 32'd1);
      checkOutput($sformatf("stall_addr%0d", i), 32'(flashAddress), 32'h10);
      @(negedge clk);
    end
    waitValid("stall_valid");
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("hold_byte%0d", i), 32'(outByte), 32'hAA);
      checkOutput($sformatf("hold_valid%0d", i), 32'(outValid), 32'd1);
      @(negedge clk);
    end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkOutput("hold_next_byte", 32'(outByte), 32'hBB);
    stopPulse();
    checkOutput("have_stop_busy", 32'(busy), 32'd0);
    checkOutput("have_stop_valid", 32'(outValid), 32'd0);
    checkOutput("stall_one_read", 32'(readCount - readsBefore), 32'd1);

    $display("[TB] stop while waiting for read data");
    latency = 4;
    readsBefore = readCount;
    applyStimulus(23'h10, 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("sw_wait_read", 32'(flashRead), 32'd0);
    stopPulse();
    sawAny = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("sw_busy%0d", i), 32'(busy), 32'd1);
      sawAny = sawAny | outValid;
      @(negedge clk);
    end
    checkOutput("sw_idle_after_rdv", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      sawAny = sawAny | outValid | flashRead;
      @(negedge clk);
    end
    checkOutput("sw_no_valid_or_read", 32'(sawAny), 32'd0);
    checkOutput("sw_one_read", 32'(readCount - readsBefore), 32'd1);
    latency = 0;

    $display("[TB] reverse raised on a transfer");
    applyStimulus(23'h10, 2'd1, 1'b0, 1'b0);
    waitValid("tog_valid");
    checkOutput("tog_first_byte", 32'(outByte), 32'hBB);
    reverse = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    reverse = 1'b0;
    checkOutput("tog_rev_byte", 32'(outByte), 32'hAA);
    checkOutput("tog_rev_valid", 32'(outValid), 32'd1);
    @(negedge clk);
    checkOutput("tog_held_byte", 32'(outByte), 32'hAA);
    stopPulse();
    checkOutput("tog_stop_busy", 32'(busy), 32'd0);

    $display("[TB] single-word window stays in the word");
    hiWord = 23'h10;
    readsBefore = readCount;
    applyStimulus(23'h10, 2'd3, 1'b0, 1'b1);
    collectStream(2);
    stopPulse();
    checkOutput("one_nbytes", 32'(gotBytes.size()), 32'd2);
    checkOutput("one_byte0", 32'(gotBytes[0]), 32'hDD);
    checkOutput("one_byte1", 32'(gotBytes[1]), 32'hAA);
    checkOutput("one_reads", 32'(readCount - readsBefore), 32'd1);
    hiWord = 23'h11;

    $display("[TB] asynchronous reset during a stalled request");
    stallLeft = 1000;
    applyStimulus(23'h11, 2'd2, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("ar_read_before", 32'(flashRead), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("ar_read", 32'(flashRead), 32'd0);
    checkOutput("ar_busy", 32'(busy), 32'd0);
    checkOutput("ar_addr", 32'(flashAddress), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stallLeft = 0;
    @(posedge clk);
    #1 forceRdv = 1'b1;
    @(posedge clk);
    #1 forceRdv = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("stray_rdv_valid", 32'(outValid), 32'd0);
    checkOutput("stray_rdv_busy", 32'(busy), 32'd0);
    checkOutput("stray_rdv_byte", 32'(outByte), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
